// File: rtl/match_serializer.sv
// -----------------------------------------------------------------------------
// match_serializer
//
// Takes one vector of N rule-ID slots at a time and emits each nonzero slot
// as a separate output beat. Beats come out in ascending slot order, one per
// cycle while downstream is ready. A vector with no nonzero slot produces a
// single "none" beat (out=0, out_none=1, out_last=1).
//
// When the last beat of a vector handshakes, the next vector can be accepted
// in the same cycle. Its first beat then follows on the next cycle, so there
// is no bubble between vectors.
//
// Parameters
//   N              number of slots in one input vector
//   log_N          log2(N)
//   elements_width width of one rule ID (0 marks an empty slot)
//
// Ports
//   clk            clock; all state updates on its rising edge
//   reset          synchronous, active-high reset
//   in_valid       upstream vector present
//   in_ready       block accepts a vector this cycle
//   in             slot i at [i*elements_width +: elements_width]
//   out_valid      output beat present
//   out_ready      downstream accepts the beat
//   out            rule ID of the current beat
//   out_last       final beat of the current vector
//   out_none       current vector had no nonzero slot
//   out_cnt        number of nonzero slots in the current vector (0..N)
// -----------------------------------------------------------------------------
module match_serializer #(
  parameter int N              = 8,
  parameter int log_N          = 3,
  parameter int elements_width = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [0:N*elements_width-1]     in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [0:elements_width-1]       out,
  output logic                            out_last,
  output logic                            out_none,
  output logic [0:log_N]                  out_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    NONE = 2'd2
  } state_t;

  state_t                        state_q;
  logic [0:N*elements_width-1]   data_q;
  logic [N-1:0]                  mask_q;
  logic [log_N:0]                cnt_q;

  logic [N-1:0]                  in_mask;
  logic [log_N:0]                in_cnt;
  logic [N-1:0]                  first_onehot;
  logic                          one_left;
  logic [elements_width-1:0]     sel_id;
  logic                          in_hs;
  logic                          out_hs;

  // Occupancy and popcount of the incoming vector.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    in_mask = '0;
    in_cnt  = '0;
    for (int i = 0; i < N; i++) begin
      in_mask[i] = |in[i*elements_width +: elements_width];
      in_cnt     = in_cnt + {{log_N{1'b0}}, in_mask[i]};
    end
  end

  // Lowest pending slot: x & -x isolates the least significant set bit.
  assign first_onehot = mask_q & (~mask_q + {{(N-1){1'b0}}, 1'b1});
  assign one_left     = (mask_q != '0) && (mask_q == first_onehot);

  always_comb begin
    sel_id = '0;
    for (int i = 0; i < N; i++) begin
      if (first_onehot[i]) sel_id = data_q[i*elements_width +: elements_width];
    end
  end

  // Outputs are decoded from registered state only; when no beat is present
  // every data output is forced to zero.
  assign out_valid = (state_q != IDLE);
  assign out       = (state_q == SEND) ? sel_id : '0;
  assign out_last  = ((state_q == SEND) && one_left) || (state_q == NONE);
  assign out_none  = (state_q == NONE);
  assign out_cnt   = out_valid ? cnt_q : '0;

  assign out_hs   = out_valid && out_ready;
  // Ready also during the handshake of the final beat, so a waiting vector
  // is taken in the same cycle and the output never idles between vectors.
  assign in_ready = (state_q == IDLE) || (out_hs && out_last);
  assign in_hs    = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Reset wins over any handshake in the same cycle; the remaining beats
      // of an in-flight vector are dropped with the mask.
      state_q <= IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else if (in_hs) begin
      data_q  <= in;
      mask_q  <= in_mask;
      cnt_q   <= in_cnt;
      state_q <= (in_mask == '0) ? NONE : SEND;
    end else if (out_hs) begin
      if (out_last) begin
        state_q <= IDLE;
        mask_q  <= '0;
      end else begin
        mask_q  <= mask_q & ~first_onehot;
      end
    end
  end

endmodule

// File: tb/tb_match_serializer.sv
// -----------------------------------------------------------------------------
// tb_match_serializer
//
// Drives match_serializer (N=8, elements_width=4) with directed and random
// vectors. A reference model keeps the queue of beats still owed for the
// current vector, built straight from the vector contents (nonzero slots in
// ascending order, or a single "none" beat). Inputs change and outputs are
// compared on the falling edge; handshakes are resolved on the rising edge.
// -----------------------------------------------------------------------------
module tb_match_serializer;

  localparam int N  = 8;
  localparam int LN = 3;
  localparam int EW = 4;
  localparam int VW = N * EW;

  typedef struct packed {
    logic [EW-1:0] id;
    logic          last;
    logic          none;
    logic [LN:0]   cnt;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [0:VW-1]   in_vec;
  logic            out_valid;
  logic            out_ready;
  logic [0:EW-1]   out_id;
  logic            out_last;
  logic            out_none;
  logic [0:LN]     out_cnt;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  beat_t exp_q[$];

  match_serializer #(
    .N              (N),
    .log_N          (LN),
    .elements_width (EW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_id),
    .out_last  (out_last),
    .out_none  (out_none),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [0:VW-1] pack(input int s[N]);
    logic [0:VW-1] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*EW +: EW] = s[i][EW-1:0];
    return v;
  endfunction

  // Beats owed for one accepted vector.
  function automatic void push_vector(input logic [0:VW-1] v);
    int    ids[$];
    beat_t b;
    for (int i = 0; i < N; i++) begin
      if (v[i*EW +: EW] != 0) ids.push_back(int'(v[i*EW +: EW]));
    end
    if (ids.size() == 0) begin
      b = '{id: '0, last: 1'b1, none: 1'b1, cnt: '0};
      exp_q.push_back(b);
    end else begin
      for (int k = 0; k < ids.size(); k++) begin
        b.id   = ids[k][EW-1:0];
        b.last = (k == ids.size() - 1);
        b.none = 1'b0;
        b.cnt  = ids.size();
        exp_q.push_back(b);
      end
    end
  endfunction

  // One clock cycle: apply inputs at the falling edge, compare every output
  // against the model, then resolve handshakes at the rising edge.
  task automatic step(input string tag, input logic iv, input logic [0:VW-1] v,
                      input logic ordy, output logic acc);
    logic  exp_ir;
    logic  exp_ov;
    beat_t h;
    in_valid  = iv;
    in_vec    = v;
    out_ready = ordy;
    #1;
    exp_ov = (exp_q.size() != 0);
    h      = exp_ov ? exp_q[0] : beat_t'('0);
    exp_ir = !exp_ov || (ordy && h.last);

    n_checks++;
    if (out_valid !== exp_ov) begin
      n_fail++;
      $display("FAIL %s cyc %0d out_valid: got %b want %b", tag, cyc, out_valid, exp_ov);
    end
    n_checks++;
    if (in_ready !== exp_ir) begin
      n_fail++;
      $display("FAIL %s cyc %0d in_ready: got %b want %b", tag, cyc, in_ready, exp_ir);
    end
    n_checks++;
    if (out_id !== h.id) begin
      n_fail++;
      $display("FAIL %s cyc %0d out: got %0d want %0d", tag, cyc, out_id, h.id);
    end
    n_checks++;
    if (out_last !== h.last) begin
      n_fail++;
      $display("FAIL %s cyc %0d out_last: got %b want %b", tag, cyc, out_last, h.last);
    end
    n_checks++;
    if (out_none !== h.none) begin
      n_fail++;
      $display("FAIL %s cyc %0d out_none: got %b want %b", tag, cyc, out_none, h.none);
    end
    n_checks++;
    if (out_cnt !== h.cnt) begin
      n_fail++;
      $display("FAIL %s cyc %0d out_cnt: got %0d want %0d", tag, cyc, out_cnt, h.cnt);
    end

    @(posedge clk);
    acc = iv && exp_ir;
    if (exp_ov && ordy) void'(exp_q.pop_front());
    if (acc) push_vector(v);
    @(negedge clk);
    cyc++;
  endtask

  // One reset cycle with live handshake inputs; reset must win.
  task automatic pulse_reset(input logic iv, input logic [0:VW-1] v, input logic ordy);
    reset     = 1'b1;
    in_valid  = iv;
    in_vec    = v;
    out_ready = ordy;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    cyc++;
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic acc;
    int   budget = 40;
    while (exp_q.size() != 0 && budget > 0) begin
      step(tag, 1'b0, '0, 1'b1, acc);
      budget--;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain timeout: got %0d beats left want 0", tag, exp_q.size());
    end
    step(tag, 1'b0, '0, 1'b1, acc);  // idle cycle after the vector
  endtask

  task automatic test_reset();
    logic acc;
    pulse_reset(1'b1, 32'hFFFF_FFFF, 1'b1);
    step("reset", 1'b0, 32'h1234_5678, 1'b0, acc);
    step("reset", 1'b0, '0, 1'b1, acc);
  endtask

  task automatic test_basic();
    int   s[N];
    logic acc;
    s = '{0, 3, 0, 0, 7, 0, 0, 9};
    step("basic", 1'b1, pack(s), 1'b1, acc);
    n_checks++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL basic accept: got %b want 1", acc);
    end
    drain("basic");
  endtask

  task automatic test_none();
    logic acc;
    step("none", 1'b1, '0, 1'b1, acc);
    drain("none");
  endtask

  task automatic test_backpressure();
    int   s[N];
    logic acc;
    s = '{5, 0, 0, 0, 0, 0, 0, 6};
    step("stall", 1'b1, pack(s), 1'b0, acc);
    for (int k = 0; k < 4; k++) step("stall", 1'b0, '0, 1'b0, acc);
    drain("stall");
  endtask

  task automatic test_back_to_back();
    int   s[N];
    int   s2[N];
    logic acc;
    int   guard = 10;
    s  = '{0, 3, 0, 0, 7, 0, 0, 9};
    s2 = '{0, 0, 2, 0, 0, 0, 0, 0};
    step("b2b", 1'b1, pack(s), 1'b1, acc);
    acc = 1'b0;
    while (!acc && guard > 0) begin
      step("b2b", 1'b1, pack(s2), 1'b1, acc);
      guard--;
    end
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL b2b second vector: got not accepted want accepted");
    end
    drain("b2b");
  endtask

  task automatic test_reset_midframe();
    int   s[N];
    logic acc;
    s = '{0, 3, 0, 0, 7, 0, 0, 9};
    step("midrst", 1'b1, pack(s), 1'b1, acc);
    step("midrst", 1'b0, '0, 1'b1, acc);  // beat 3
    pulse_reset(1'b1, pack(s), 1'b1);
    // Model queue is empty: any leftover beat shows up as out_valid=1.
    for (int k = 0; k < 4; k++) step("midrst", 1'b0, '0, 1'b1, acc);
  endtask

  task automatic test_full();
    int   s[N];
    logic acc;
    s = '{1, 2, 3, 4, 5, 6, 7, 8};
    step("full", 1'b1, pack(s), 1'b1, acc);
    drain("full");
  endtask

  task automatic test_random();
    int   s[N];
    logic acc;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        s[i] = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 15)) : 0;
      if ($urandom_range(0, 60) == 0)
        pulse_reset($urandom_range(0, 1) == 1, pack(s), $urandom_range(0, 1) == 1);
      else
        step("random", $urandom_range(0, 2) != 0, pack(s), $urandom_range(0, 3) != 0, acc);
    end
    drain("random");
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    test_reset();
    test_basic();
    test_none();
    test_backpressure();
    test_back_to_back();
    test_reset_midframe();
    test_full();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
